// File: rtl/radix4_seq_ctrl_pkg.sv
// Shared definitions for the radix-4 Booth sequencer:
// state encodings, Booth op bit positions and the default width.
package radix4_seq_ctrl_pkg;

    localparam int SIZE_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CALC = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Bit positions inside a packed Booth op {en, x2, neg}
    localparam int OP_EN  = 2;
    localparam int OP_X2  = 1;
    localparam int OP_NEG = 0;

    // Recode a {q[1], q[0], q[-1]} window into a Booth op
    function automatic logic [2:0] booth_op(input logic [2:0] w);
        logic [2:0] op;
        op = 3'b000;
        case (w)
            3'b001, 3'b010: op[OP_EN] = 1'b1;
            3'b011: begin
                op[OP_EN] = 1'b1;
                op[OP_X2] = 1'b1;
            end
            3'b100: begin
                op[OP_EN]  = 1'b1;
                op[OP_X2]  = 1'b1;
                op[OP_NEG] = 1'b1;
            end
            3'b101, 3'b110: begin
                op[OP_EN]  = 1'b1;
                op[OP_NEG] = 1'b1;
            end
            default: op = 3'b000;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/radix4_seq_ctrl_booth_enc.sv
// Combinational Booth recoder: multiplier window to
// partial-product enable / double / negate controls.
module booth_enc
    import radix4_seq_ctrl_pkg::*;
(
    input  logic [2:0] q_window_i,
    output logic       pp_en_o,
    output logic       pp_x2_o,
    output logic       pp_neg_o
);

    logic [2:0] op;

    assign op       = booth_op(q_window_i);
    assign pp_en_o  = op[OP_EN];
    assign pp_x2_o  = op[OP_X2];
    assign pp_neg_o = op[OP_NEG];

endmodule

// File: rtl/radix4_seq_ctrl.sv
// Radix-4 Booth multiplier sequencer: start handshake,
// register strobes, SIZE/2 Booth iterations, done pulse.
module radix4_seq_ctrl
    import radix4_seq_ctrl_pkg::*;
#(
    parameter  int SIZE = SIZE_DEFAULT,
    localparam int ITER = SIZE / 2,
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [2:0]    q_window,
    output logic          ready,
    output logic          busy,
    output logic          ld_a,
    output logic          ld_q,
    output logic          clr_p,
    output logic          ld_p,
    output logic          shift,
    output logic          pp_en,
    output logic          pp_x2,
    output logic          pp_neg,
    output logic [CW-1:0] iter,
    output logic          done
);

    if ((SIZE % 2) != 0 || SIZE < 4) begin : g_bad_size
        $error("radix4_seq_ctrl: SIZE must be even and >= 4");
    end

    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    state_e        state_q;
    logic [CW-1:0] iter_q;
    logic          ready_q;
    logic          load_q;
    logic          calc_q;
    logic          done_q;

    logic          enc_en;
    logic          enc_x2;
    logic          enc_neg;

    // State, iteration counter and registered strobes for the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            iter_q  <= '0;
            ready_q <= 1'b1;
            load_q  <= 1'b0;
            calc_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_LOAD;
                        ready_q <= 1'b0;
                        load_q  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    state_q <= ST_CALC;
                    iter_q  <= '0;
                    load_q  <= 1'b0;
                    calc_q  <= 1'b1;
                end
                ST_CALC: begin
                    if (iter_q == LAST) begin
                        state_q <= ST_DONE;
                        iter_q  <= '0;
                        calc_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        iter_q <= iter_q + CW'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    iter_q  <= '0;
                    ready_q <= 1'b1;
                    load_q  <= 1'b0;
                    calc_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    booth_enc u_booth_enc (
        .q_window_i (q_window),
        .pp_en_o    (enc_en),
        .pp_x2_o    (enc_x2),
        .pp_neg_o   (enc_neg)
    );

    assign ready  = ready_q;
    assign busy   = ~ready_q;
    assign ld_a   = load_q;
    assign ld_q   = load_q;
    assign clr_p  = load_q;
    assign ld_p   = calc_q;
    assign shift  = calc_q;
    assign pp_en  = calc_q & enc_en;
    assign pp_x2  = calc_q & enc_x2;
    assign pp_neg = calc_q & enc_neg;
    assign iter   = iter_q;
    assign done   = done_q;

endmodule
